// File: rtl/pulse_train_gen.sv
// Rectangular pulse-train generator.
// Emits num_pulses pulses of high_len cycles high and low_len cycles low
// on data_out. Every pulse gives exactly one rising edge, and edge_count
// tracks how many rising edges have been emitted in the current or last
// train. A train is started with start, can be cut short with abort, and
// signals normal completion with a single-cycle done pulse.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_len,
   input  logic [CNT_W-1:0] low_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             data_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] edge_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [NUM_W-1:0] edge_q, edge_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] l_q, l_d;
   logic [NUM_W-1:0] n_q, n_d;

   // A programmed width of zero behaves as one cycle.
   logic [CNT_W-1:0] h_eff;
   logic [CNT_W-1:0] l_eff;

   assign h_eff = (high_len == '0) ? CNT_ONE : high_len;
   assign l_eff = (low_len  == '0) ? CNT_ONE : low_len;

   // Next-state and registered-output decode for the IDLE/HIGH/LOW sequencer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      edge_d  = edge_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      l_d     = l_q;
      n_d     = n_q;

      unique case (state_q)
         IDLE: begin
            // abort has priority over start while idle
            if (start && !abort) begin
               if (num_pulses != '0) begin
                  h_d     = h_eff;
                  l_d     = l_eff;
                  n_d     = num_pulses;
                  data_d  = 1'b1;
                  busy_d  = 1'b1;
                  edge_d  = NUM_ONE;
                  cnt_d   = h_eff - CNT_ONE;
                  state_d = HIGH;
               end else begin
                  // empty train completes immediately without ever going busy
                  done_d = 1'b1;
                  edge_d = '0;
               end
            end
         end

         HIGH: begin
            if (abort) begin
               data_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               data_d  = 1'b0;
               cnt_d   = l_q - CNT_ONE;
               state_d = LOW;
            end
         end

         LOW: begin
            if (abort) begin
               data_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (edge_q == n_q) begin
               // final low gap has been emitted; train is complete
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               data_d  = 1'b1;
               edge_d  = edge_q + NUM_ONE;
               cnt_d   = h_q - CNT_ONE;
               state_d = HIGH;
            end
         end

         default: begin
            data_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, output and counter registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         edge_q  <= '0;
         cnt_q   <= '0;
         h_q     <= '0;
         l_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         edge_q  <= edge_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         l_q     <= l_d;
         n_q     <= n_d;
      end
   end

   assign data_out   = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign edge_count = edge_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen.
module tb_pulse_train_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] high_len = '0;
   logic [7:0] low_len = '0;
   logic [7:0] num_pulses = '0;
   logic       data_out;
   logic       busy;
   logic       done;
   logic [7:0] edge_count;

   int n_checks = 0;
   int n_fail   = 0;
   int edges_seen = 0;
   logic prev_data = 1'b0;

   pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .high_len   (high_len),
      .low_len    (low_len),
      .num_pulses (num_pulses),
      .data_out   (data_out),
      .busy       (busy),
      .done       (done),
      .edge_count (edge_count)
   );

   always #5 clock = ~clock;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock and settle; also acts as a loopback rising-edge detector.
   task automatic step();
      @(posedge clock);
      #1;
      if (data_out && !prev_data) edges_seen++;
      prev_data = data_out;
   endtask

   task automatic chk_idle(input string tag);
      chk_eq({tag, "_data"}, data_out, 0);
      chk_eq({tag, "_busy"}, busy, 0);
      chk_eq({tag, "_done"}, done, 0);
      chk_eq({tag, "_edges"}, edge_count, 0);
   endtask

   // Start a train, scramble the inputs afterwards, check the waveform cycle by
   // cycle against pat, and stop in the cycle where done is expected.
   task automatic run_train(input string tag, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] n, input int len, input logic [63:0] pat);
      high_len = h; low_len = l; num_pulses = n; start = 1'b1;
      edges_seen = 0;
      step();
      start = 1'b0;
      high_len = 8'd7; low_len = 8'd9; num_pulses = 8'd1;
      for (int k = 0; k < len; k++) begin
         if (k > 0) step();
         chk_eq({tag, "_data"}, data_out, pat[len-1-k]);
         chk_eq({tag, "_busy"}, busy, 1);
         chk_eq({tag, "_done_early"}, done, 0);
      end
      step();
      chk_eq({tag, "_done"}, done, 1);
      chk_eq({tag, "_busy_end"}, busy, 0);
      chk_eq({tag, "_data_end"}, data_out, 0);
      chk_eq({tag, "_edge_count"}, edge_count, n);
      chk_eq({tag, "_loopback_edges"}, edges_seen, n);
   endtask

   initial begin
      // 1. reset held with start asserted
      start = 1'b1; high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("reset");
      end
      start = 1'b0;
      reset = 1'b0;
      step();
      chk_idle("reset_release");

      // 2. normal train: 11000 x3, busy 15 cycles, done in 16th
      run_train("normal", 8'd2, 8'd3, 8'd3, 15, 64'b110001100011000);
      step();
      chk_eq("normal_done_clear", done, 0);

      // 3. zero pulse count
      num_pulses = 8'd0; high_len = 8'd2; low_len = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      chk_eq("zero_n_done", done, 1);
      chk_eq("zero_n_busy", busy, 0);
      chk_eq("zero_n_data", data_out, 0);
      chk_eq("zero_n_edges", edge_count, 0);
      step();
      chk_idle("zero_n_after");

      // 4. zero widths behave as one cycle each
      run_train("zero_w", 8'd0, 8'd0, 8'd4, 8, 64'b10101010);

      // back-to-back: start accepted in the done cycle
      high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      chk_eq("b2b_data", data_out, 1);
      chk_eq("b2b_busy", busy, 1);
      chk_eq("b2b_done", done, 0);
      chk_eq("b2b_edges", edge_count, 1);
      step();
      chk_eq("b2b_low", data_out, 0);
      step();
      chk_eq("b2b_fin_done", done, 1);
      chk_eq("b2b_fin_busy", busy, 0);
      step();
      chk_eq("b2b_done_clear", done, 0);

      // abort and start together in IDLE: abort wins
      high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd2; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk_eq("abort_idle_busy", busy, 0);
      chk_eq("abort_idle_data", data_out, 0);
      chk_eq("abort_idle_done", done, 0);

      // 5. abort during 2nd high phase, with a re-start that must be ignored
      high_len = 8'd4; low_len = 8'd4; num_pulses = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      chk_eq("abort_c1_data", data_out, 1);
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk_eq("abort_c4_data", data_out, 1);
      chk_eq("abort_c4_busy", busy, 1);
      chk_eq("abort_c4_edges", edge_count, 1);
      step();
      chk_eq("abort_c5_data", data_out, 0);
      for (int i = 0; i < 4; i++) step();
      chk_eq("abort_c9_data", data_out, 1);
      chk_eq("abort_c9_edges", edge_count, 2);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_eq("abort_data", data_out, 0);
      chk_eq("abort_busy", busy, 0);
      chk_eq("abort_done", done, 0);
      chk_eq("abort_edges", edge_count, 2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_eq("abort_after_done", done, 0);
         chk_eq("abort_after_data", data_out, 0);
         chk_eq("abort_after_edges", edge_count, 2);
      end

      // 6. reset during LOW of 2nd pulse, then restart
      high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk_eq("midrst_c9_data", data_out, 0);
      chk_eq("midrst_c9_busy", busy, 1);
      chk_eq("midrst_c9_edges", edge_count, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_idle("midrst");
      run_train("restart", 8'd1, 8'd1, 8'd2, 4, 64'b1010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
